// File: rtl/axi_ram_slave.sv
// AXI4 word-addressed RAM slave: independent write and read FSMs over a dual-port 32-bit memory.
// Define AXI_RAM_SLAVE_ERR_EN to compile in SLVERR reporting for bad size / WRAP bursts and wlast mismatches.
module axi_ram_slave #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awvalid,
    output logic                axi_awready,

    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,

    output logic                axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,

    input  logic                axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arvalid,
    output logic                axi_arready,

    output logic                axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);

    localparam int WORD_AW = ADDR_W - 2;
    localparam int DEPTH   = 2 ** WORD_AW;
    localparam int STRB_W  = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [WORD_AW-1:0] ADDR_ONE = {{(WORD_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Protocol-error detection; constant 0 when the checking build option is off.
    logic aw_err;
    logic ar_err;
    logic wlast_bad;

    // Write-side state
    w_state_e           w_state_q, w_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic               bid_q, bid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [WORD_AW-1:0] waddr_q, waddr_d;
    logic [7:0]         wlen_q, wlen_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic               wfixed_q, wfixed_d;
    logic               wbad_q, wbad_d;
    logic               wlast_err_q, wlast_err_d;
    logic               mem_we;

    // Read-side state
    r_state_e           r_state_q, r_state_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic               rid_q, rid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [WORD_AW-1:0] raddr_q, raddr_d;
    logic [7:0]         rlen_q, rlen_d;
    logic [7:0]         rcnt_q, rcnt_d;
    logic               rfixed_q, rfixed_d;
    logic               rbad_q, rbad_d;
    logic [DATA_W-1:0]  rd_word;

    logic [3:0] addr_unused;
    assign addr_unused = {axi_awaddr[1:0], axi_araddr[1:0]};

`ifdef AXI_RAM_SLAVE_ERR_EN
    assign aw_err    = (axi_awsize != 3'd2) || (axi_awburst == 2'b10);
    assign ar_err    = (axi_arsize != 3'd2) || (axi_arburst == 2'b10);
    assign wlast_bad = axi_wlast != (wcnt_q == wlen_q);
`else
    logic [6:0] cfg_unused;
    assign cfg_unused = {axi_awsize, axi_arsize, axi_wlast};
    assign aw_err     = 1'b0;
    assign ar_err     = 1'b0;
    assign wlast_bad  = 1'b0;
`endif

    // ---------------------------------------------------------------- write FSM
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned; otherwise a latch is inferred.
        w_state_d   = w_state_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wfixed_d    = wfixed_q;
        wbad_d      = wbad_q;
        wlast_err_d = wlast_err_q;
        mem_we      = 1'b0;

        unique case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid && awready_q) begin
                    w_state_d   = W_DATA;
                    bid_d       = axi_awid;
                    waddr_d     = axi_awaddr[ADDR_W-1:2];
                    wlen_d      = axi_awlen;
                    wcnt_d      = '0;
                    wfixed_d    = (axi_awburst == BURST_FIXED);
                    wbad_d      = aw_err;
                    wlast_err_d = 1'b0;
                end
            end
            W_DATA: begin
                if (axi_wvalid && wready_q) begin
                    mem_we      = !wbad_q;
                    wcnt_d      = wcnt_q + 8'd1;
                    wlast_err_d = wlast_err_q | wlast_bad;
                    if (!wfixed_q) begin
                        waddr_d = waddr_q + ADDR_ONE;
                    end
                    // The beat counter alone ends the burst; wlast only affects the response.
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                        bresp_d   = (wbad_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; always_comb uses blocking (=).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= 1'b0;
            bresp_q     <= RESP_OKAY;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wfixed_q    <= 1'b0;
            wbad_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            waddr_q     <= waddr_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            wfixed_q    <= wfixed_d;
            wbad_q      <= wbad_d;
            wlast_err_q <= wlast_err_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (mem_we && axi_wstrb[b]) begin
                mem[waddr_q][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    // Sampled into rdata_q at the same edge as a colliding write, so the old word is returned.
    assign rd_word = mem[raddr_q];

    // ---------------------------------------------------------------- read FSM
    always_comb begin
        r_state_d = r_state_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rfixed_d  = rfixed_q;
        rbad_d    = rbad_q;

        unique case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid && arready_q) begin
                    r_state_d = R_READ;
                    rid_d     = axi_arid;
                    raddr_d   = axi_araddr[ADDR_W-1:2];
                    rlen_d    = axi_arlen;
                    rcnt_d    = '0;
                    rfixed_d  = (axi_arburst == BURST_FIXED);
                    rbad_d    = ar_err;
                end
            end
            R_READ: begin
                r_state_d = R_DATA;
                rdata_d   = rbad_q ? '0 : rd_word;
                rresp_d   = rbad_q ? RESP_SLVERR : RESP_OKAY;
                rlast_d   = (rcnt_q == rlen_q);
            end
            R_DATA: begin
                if (axi_rready && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        r_state_d = R_READ;
                        rcnt_d    = rcnt_q + 8'd1;
                        if (!rfixed_q) begin
                            raddr_d = raddr_q + ADDR_ONE;
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rfixed_q  <= 1'b0;
            rbad_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rfixed_q  <= rfixed_d;
            rbad_q    <= rbad_d;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bid_q;
    assign axi_bresp   = bresp_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Self-checking bench for axi_ram_slave: directed and randomized bursts against a word-array reference model.
// Expectations for error bursts follow AXI_RAM_SLAVE_ERR_EN when it is defined.
module tb_axi_ram_slave;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              axi_awid = 1'b0;
    logic [ADDR_W-1:0] axi_awaddr = '0;
    logic [7:0]        axi_awlen = '0;
    logic [2:0]        axi_awsize = '0;
    logic [1:0]        axi_awburst = '0;
    logic              axi_awvalid = 1'b0;
    logic              axi_awready;
    logic [DATA_W-1:0] axi_wdata = '0;
    logic [3:0]        axi_wstrb = '0;
    logic              axi_wlast = 1'b0;
    logic              axi_wvalid = 1'b0;
    logic              axi_wready;
    logic              axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready = 1'b0;
    logic              axi_arid = 1'b0;
    logic [ADDR_W-1:0] axi_araddr = '0;
    logic [7:0]        axi_arlen = '0;
    logic [2:0]        axi_arsize = '0;
    logic [1:0]        axi_arburst = '0;
    logic              axi_arvalid = 1'b0;
    logic              axi_arready;
    logic              axi_rid;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready = 1'b0;

    axi_ram_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [int];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI_RAM_SLAVE_ERR_EN
        return (size != 3'd2) || (burst == WRAP);
`else
        return 1'b0 & (size[0] ^ burst[0]);
`endif
    endfunction

    // Word touched by beat i: FIXED stays put, anything else counts up modulo the depth.
    function automatic int beat_word(input int base_byte, input int i, input logic [1:0] burst);
        int w;
        w = (base_byte >> 2) % DEPTH;
        return (burst == FIXED) ? w : (w + i) % DEPTH;
    endfunction

    task automatic write_burst(input logic id, input int addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input int bdelay);
        int n;
        int w;
        logic [31:0] word;
        logic [1:0] exp_resp;
        exp_resp = is_err(size, burst) ? 2'b10 : 2'b00;
        if (!is_err(size, burst)) begin
            for (int i = 0; i <= len; i++) begin
                w = beat_word(addr, i, burst);
                word = model_mem.exists(w) ? model_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (wq_strb[i][b]) word[8*b +: 8] = wq_data[i][8*b +: 8];
                model_mem[w] = word;
            end
        end
        axi_awid = id; axi_awaddr = addr[ADDR_W-1:0]; axi_awlen = len[7:0];
        axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi_wdata = wq_data[i]; axi_wstrb = wq_strb[i]; axi_wlast = (i == len); axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < 50) begin @(negedge clk); n++; end
            check("w_accept", 32'(n < 50), 32'd1);
            @(negedge clk);
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        n = 0;
        while (!axi_bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_arrive", 32'(n < 50), 32'd1);
        check("bresp", 32'(axi_bresp), 32'(exp_resp));
        check("bid", 32'(axi_bid), 32'(id));
        repeat (bdelay) begin
            @(negedge clk);
            check("bvalid_hold", 32'(axi_bvalid), 32'd1);
            check("bid_hold", 32'(axi_bid), 32'(id));
        end
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        check("bvalid_drop", 32'(axi_bvalid), 32'd0);
        wq_data.delete(); wq_strb.delete();
    endtask

    task automatic read_burst(input logic id, input int addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input bit rand_ready, input bit check_lat);
        logic [31:0] exp_data [$];
        logic [1:0]  exp_resp [$];
        int n, got, cyc, w;
        bit pend;
        logic [31:0] hold_data;
        logic hold_last;
        for (int i = 0; i <= len; i++) begin
            w = beat_word(addr, i, burst);
            exp_data.push_back(is_err(size, burst) ? 32'h0 : model_mem[w]);
            exp_resp.push_back(is_err(size, burst) ? 2'b10 : 2'b00);
        end
        axi_arid = id; axi_araddr = addr[ADDR_W-1:0]; axi_arlen = len[7:0];
        axi_arsize = size; axi_arburst = burst; axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        if (check_lat) begin
            check("r_lat_cycle1", 32'(axi_rvalid), 32'd0);
            @(negedge clk);
            check("r_lat_cycle2", 32'(axi_rvalid), 32'd1);
        end
        got = 0; cyc = 0; pend = 1'b0; hold_data = '0; hold_last = 1'b0;
        while (got <= len && cyc < 1000) begin
            axi_rready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (axi_rvalid) begin
                if (pend) begin
                    check("r_hold_data", axi_rdata, hold_data);
                    check("r_hold_last", 32'(axi_rlast), 32'(hold_last));
                end
                if (axi_rready) begin
                    check("rdata", axi_rdata, exp_data[got]);
                    check("rresp", 32'(axi_rresp), 32'(exp_resp[got]));
                    check("rlast", 32'(axi_rlast), 32'(got == len));
                    check("rid", 32'(axi_rid), 32'(id));
                    last_rdata = axi_rdata;
                    last_rresp = axi_rresp;
                    got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    hold_data = axi_rdata;
                    hold_last = axi_rlast;
                end
            end else if (pend) begin
                check("r_hold_valid", 32'(axi_rvalid), 32'd1);
                pend = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        axi_rready = 1'b0;
        check("r_beat_count", 32'(got), 32'(len + 1));
        repeat (3) @(negedge clk);
        check("r_no_extra", 32'(axi_rvalid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, word, n;
        logic [1:0] burst;
        logic [31:0] old_word, new_word;
        bit bv_seen;

        // ---- reset values
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(axi_awready), 32'd0);
        check("rst_wready", 32'(axi_wready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_arready", 32'(axi_arready), 32'd0);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rlast", 32'(axi_rlast), 32'd0);
        check("rst_bresp", 32'(axi_bresp), 32'd0);
        check("rst_rresp", 32'(axi_rresp), 32'd0);
        check("rst_bid", 32'(axi_bid), 32'd0);
        check("rst_rid", 32'(axi_rid), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        rst = 1'b0;
        check("rel_awready_same", 32'(axi_awready), 32'd0);
        @(negedge clk);
        check("rel_awready_next", 32'(axi_awready), 32'd1);
        check("rel_arready_next", 32'(axi_arready), 32'd1);

        // ---- INCR len 3 at 0x10
        for (int i = 0; i < 4; i++) begin wq_data.push_back(32'hA0 + 32'(i)); wq_strb.push_back(4'hF); end
        write_burst(1'b1, 'h10, 3, 3'd2, INCR, 0);
        read_burst(1'b1, 'h10, 3, 3'd2, INCR, 1'b0, 1'b1);
        check("incr_last_beat", last_rdata, 32'hA3);

        // ---- byte strobes
        wq_data.push_back(32'hFFFF_FFFF); wq_strb.push_back(4'hF);
        write_burst(1'b0, 'h20, 0, 3'd2, INCR, 0);
        wq_data.push_back(32'h0000_1200); wq_strb.push_back(4'h2);
        write_burst(1'b0, 'h20, 0, 3'd2, INCR, 0);
        read_burst(1'b0, 'h20, 0, 3'd2, INCR, 1'b0, 1'b0);
        check("strobe_merge", last_rdata, 32'hFFFF_12FF);

        // ---- wrap past the top word, FIXED burst
        wq_data.push_back(32'hC0DE_0001); wq_strb.push_back(4'hF);
        wq_data.push_back(32'hC0DE_0002); wq_strb.push_back(4'hF);
        write_burst(1'b1, (1 << ADDR_W) - 4, 1, 3'd2, INCR, 0);
        read_burst(1'b1, (1 << ADDR_W) - 4, 0, 3'd2, INCR, 1'b0, 1'b0);
        check("top_word", last_rdata, 32'hC0DE_0001);
        read_burst(1'b0, 'h0, 0, 3'd2, INCR, 1'b0, 1'b0);
        check("wrap_to_zero", last_rdata, 32'hC0DE_0002);
        wq_data.push_back(32'h11); wq_strb.push_back(4'hF);
        wq_data.push_back(32'h22); wq_strb.push_back(4'hF);
        wq_data.push_back(32'h33); wq_strb.push_back(4'hF);
        write_burst(1'b0, 'h40, 2, 3'd2, FIXED, 0);
        read_burst(1'b0, 'h40, 0, 3'd2, INCR, 1'b0, 1'b0);
        check("fixed_last_value", last_rdata, 32'h33);

        // ---- randomized region 0x100..0x13F with back-pressure
        for (int i = 0; i < 64; i++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        write_burst(1'b0, 'h400, 63, 3'd2, INCR, 10);
        for (int t = 0; t < 12; t++) begin
            len   = $urandom_range(0, 7);
            word  = 'h100 + $urandom_range(0, 56);
            burst = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
            for (int i = 0; i <= len; i++) begin
                wq_data.push_back($urandom);
                wq_strb.push_back(4'($urandom_range(0, 15)));
            end
            write_burst($urandom_range(0, 1) == 1, word * 4, len, 3'd2, burst, $urandom_range(0, 3));
        end
        for (int t = 0; t < 12; t++) begin
            len   = $urandom_range(0, 7);
            word  = 'h100 + $urandom_range(0, 56);
            burst = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
            read_burst($urandom_range(0, 1) == 1, word * 4, len, 3'd2, burst, 1'b1, 1'b0);
        end

        // ---- protocol-error handling (resp depends on build option)
        wq_data.push_back(32'hDEAD_BEEF); wq_strb.push_back(4'hF);
        write_burst(1'b1, 'h20, 0, 3'd1, INCR, 0);
        read_burst(1'b0, 'h20, 0, 3'd2, INCR, 1'b0, 1'b0);
`ifdef AXI_RAM_SLAVE_ERR_EN
        check("bad_size_mem_kept", last_rdata, 32'hFFFF_12FF);
`else
        check("bad_size_mem_written", last_rdata, 32'hDEAD_BEEF);
`endif
        read_burst(1'b1, 'h10, 1, 3'd2, WRAP, 1'b1, 1'b0);
`ifdef AXI_RAM_SLAVE_ERR_EN
        check("wrap_rresp", 32'(last_rresp), 32'h2);
`else
        check("wrap_rresp", 32'(last_rresp), 32'h0);
`endif

        // ---- read and write of the same word in the same cycle
        old_word = model_mem['h101];
        new_word = 32'h5A5A_0101;
        axi_awid = 1'b0; axi_awaddr = 14'h404; axi_awlen = 8'd0; axi_awsize = 3'd2;
        axi_awburst = INCR; axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < 50) begin @(negedge clk); n++; end
        check("col_aw_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        check("col_arready", 32'(axi_arready), 32'd1);
        axi_arid = 1'b0; axi_araddr = 14'h404; axi_arlen = 8'd0; axi_arsize = 3'd2;
        axi_arburst = INCR; axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        axi_wdata = new_word; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        @(negedge clk);
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        check("col_rvalid", 32'(axi_rvalid), 32'd1);
        check("col_old_word", axi_rdata, old_word);
        check("col_bvalid", 32'(axi_bvalid), 32'd1);
        axi_rready = 1'b1; axi_bready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0; axi_bready = 1'b0;
        model_mem['h101] = new_word;
        read_burst(1'b0, 'h404, 0, 3'd2, INCR, 1'b0, 1'b0);
        check("col_new_word", last_rdata, new_word);

        // ---- reset during beat 2 of a len-7 write
        axi_awid = 1'b1; axi_awaddr = 14'h200; axi_awlen = 8'd7; axi_awsize = 3'd2;
        axi_awburst = INCR; axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < 50) begin @(negedge clk); n++; end
        check("rb_aw_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_wdata = 32'h5000_0000 + 32'(i); axi_wstrb = 4'hF; axi_wlast = 1'b0; axi_wvalid = 1'b1;
            model_mem['h80 + i] = 32'h5000_0000 + 32'(i);
            n = 0;
            while (!axi_wready && n < 50) begin @(negedge clk); n++; end
            check("rb_w_accept", 32'(n < 50), 32'd1);
            @(negedge clk);
        end
        axi_wdata = 32'h5000_0002;
        #2 rst = 1'b1;
        #1;
        check("rb_awready_rst", 32'(axi_awready), 32'd0);
        check("rb_wready_rst", 32'(axi_wready), 32'd0);
        check("rb_arready_rst", 32'(axi_arready), 32'd0);
        @(negedge clk);
        axi_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rb_awready_release", 32'(axi_awready), 32'd0);
        @(negedge clk);
        check("rb_awready_back", 32'(axi_awready), 32'd1);
        check("rb_arready_back", 32'(axi_arready), 32'd1);
        bv_seen = 1'b0;
        repeat (20) begin
            axi_bready = 1'b1;
            @(negedge clk);
            bv_seen |= axi_bvalid;
        end
        axi_bready = 1'b0;
        check("rb_no_bvalid", 32'(bv_seen), 32'd0);
        read_burst(1'b1, 'h200, 1, 3'd2, INCR, 1'b0, 1'b0);
        read_burst(1'b0, 'h10, 3, 3'd2, INCR, 1'b1, 1'b0);
        check("rb_mem_retained", last_rdata, 32'hA3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, AXI byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have the AW channel: axi_awid in 1, axi_awaddr in ADDR_W, axi_awlen in 8, axi_awsize in 3, axi_awburst in 2, axi_awvalid in 1, axi_awready out 1.
REQ-006 SHALL have the W channel: axi_wdata in DATA_W, axi_wstrb in DATA_W/8, axi_wlast in 1, axi_wvalid in 1, axi_wready out 1.
REQ-007 SHALL have the B channel: axi_bid out 1, axi_bresp out 2, axi_bvalid out 1, axi_bready in 1.
REQ-008 SHALL have the AR channel: axi_arid in 1, axi_araddr in ADDR_W, axi_arlen in 8, axi_arsize in 3, axi_arburst in 2, axi_arvalid in 1, axi_arready out 1.
REQ-009 SHALL have the R channel: axi_rid out 1, axi_rdata out DATA_W, axi_rresp out 2, axi_rlast out 1, axi_rvalid out 1, axi_rready in 1.

Function
REQ-010 SHALL implement a dual-port word memory: one write port owned by the write FSM, one read port owned by the read FSM, both operating independently and concurrently.
REQ-011 SHALL use a write FSM with states W_IDLE, W_DATA and W_RESP; axi_awready SHALL be 1 only in W_IDLE.
REQ-012 SHALL, on an AW handshake in W_IDLE, latch id, word address (awaddr[ADDR_W-1:2]), len and burst, clear the beat counter, and enter W_DATA on the next cycle.
REQ-013 SHALL assert axi_wready in W_DATA; each W handshake writes the bytes enabled by wstrb at the current word address.
REQ-014 SHALL advance the address after each beat: INCR adds 1 modulo depth (wraps to 0 at the top word); FIXED holds the address.
REQ-015 SHALL enter W_RESP after the beat where the beat counter equals len; bvalid=1 and bid=latched id are held stable until bready, then the FSM returns to W_IDLE.
REQ-016 SHALL use a read FSM with states R_IDLE, R_READ and R_DATA; axi_arready SHALL be 1 only in R_IDLE.
REQ-017 SHALL, on an AR handshake, latch the AR fields and go to R_READ; R_READ registers the memory word into rdata and goes to R_DATA; first rvalid occurs 2 cycles after the AR handshake.
REQ-018 SHALL, in R_DATA, hold rvalid, rdata, rid and rlast stable until rready; rlast=1 only on beat len; after the handshake go to R_IDLE if last, else to R_READ with the next address (REQ-014 rules); throughput is 1 beat per 2 cycles.
REQ-019 SHALL return the old word when a read and a write target the same address in the same cycle.
REQ-020 SHALL drive bresp and rresp as OKAY (2'b00) except as specified in REQ-027.
REQ-021 SHALL support a len=0 burst as a single beat: one wlast/rlast beat.

Reset
REQ-022 SHALL, while rst=1, force awready, wready, bvalid, arready, rvalid and rlast to 0, bresp, rresp, bid, rid and rdata to 0, and both FSMs to their IDLE states.
REQ-023 SHALL register awready and arready, which rise on the first clk edge after rst falls.
REQ-024 SHALL abort any burst in progress when rst is asserted mid-burst, with no B or R response issued afterwards; memory contents SHALL NOT be reset.

Configuration
REQ-025 SHALL compile protocol-error checking in only when macro AXI_RAM_SLAVE_ERR_EN is defined.
REQ-026 SHALL, without AXI_RAM_SLAVE_ERR_EN, ignore size, burst type WRAP (treated as INCR) and wlast, and always respond OKAY.
REQ-027 SHALL, with AXI_RAM_SLAVE_ERR_EN, flag a burst as erroneous when awsize/arsize != 2 or burst == 2'b10; an erroneous burst consumes all beats without writing memory, and bresp / every rresp = SLVERR (2'b10) with rdata=0. A wlast value that disagrees with the beat counter SHALL also set bresp=SLVERR, while the burst still ends on the counter.

Verification
REQ-028 SHALL check: AW addr 0x10, len 3, INCR; W data 0xA0..0xA3, wstrb 0xF -> bresp 00; AR addr 0x10, len 3 -> rdata 0xA0..0xA3 with rlast on the 4th beat.
REQ-029 SHALL check: write 0xFFFFFFFF to 0x20, then wstrb 0x2 data 0x00001200 -> read 0x20 returns 0xFFFF12FF.
REQ-030 SHALL check: INCR len 1 at the top word (2**ADDR_W-4) -> the second beat lands at address 0; FIXED len 2 -> the last beat value remains in memory.
REQ-031 SHALL check: bready held low 10 cycles and rready toggled randomly -> bvalid, bid, rvalid and rdata stay stable, with no lost or duplicated beats.
REQ-032 SHALL check, with AXI_RAM_SLAVE_ERR_EN: awsize 1 -> bresp 10 and memory unchanged; arburst 2'b10 -> every rresp 10; without the macro, the same stimulus -> resp 00.
REQ-033 SHALL check: rst pulsed during beat 2 of a len-7 write -> awready/arready return to 1 one cycle after release, and no bvalid is seen.
